// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter that shares one output channel between N_REQ
//   valid/ready requesters. A grant is held for a whole packet, until the beat
//   flagged last is accepted. The granted index drives the select of an
//   internal N_REQ:1 data mux.
//
//   Optional build macro MUX_RR_ARB_BURST_LIMIT_EN: caps a grant at MAX_BURST
//   beats. The requester is re-arbitrated later and resumes its packet.
//   burst_cut pulses for one cycle after a forced release.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     per-requester beat valid
//   in_last      per-requester end-of-packet (qualified by in_valid)
//   in_data      requester i on bits [i*W +: W]
//   in_ready     per-requester accept
//   out_valid    shared channel valid
//   out_last     shared channel end-of-packet
//   out_data     shared channel data
//   out_ready    consumer accept
//   grant        one-hot current grant, zero when idle
//   grant_idx    current grant index, holds the last index when idle
//   busy         high while a grant is active
//   burst_cut    (macro only) one-cycle pulse after a forced release
module mux_rr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           in_valid,
  input  logic [N_REQ-1:0]           in_last,
  input  logic [N_REQ*W-1:0]         in_data,
  output logic [N_REQ-1:0]           in_ready,
  output logic                       out_valid,
  output logic                       out_last,
  output logic [W-1:0]               out_data,
  input  logic                       out_ready,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   grant_idx,
  output logic                       busy
`ifdef MUX_RR_ARB_BURST_LIMIT_EN
  ,
  output logic                       burst_cut
`endif
);

  localparam int IW = $clog2(N_REQ);

  // Elaboration-time guard on the legal parameter ranges.
  if ((N_REQ < 2) || (N_REQ > 16) || (MAX_BURST < 1) || (W < 1)) begin : g_param_check
    $error("mux_rr_arbiter: illegal parameter value");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [N_REQ-1:0]   grant_r, grant_nxt_s;
  logic [IW-1:0]      grant_idx_r, grant_idx_nxt_s;
  logic [IW-1:0]      ptr_r, ptr_nxt_s;
  logic               busy_r;

  logic [IW-1:0]      pick_idx_s;
  logic               pick_vld_s;
  logic               out_valid_s, out_last_s;
  logic [W-1:0]       out_data_s;
  logic [N_REQ-1:0]   in_ready_s;
  logic               xfer_s, release_s;

  // N_REQ:1 AND-OR mux cell: exactly one leg matches the select.
  function automatic logic [W-1:0] mux_cell(input logic [N_REQ*W-1:0] d,
                                            input logic [IW-1:0]      sel);
    logic [W-1:0] r;
    r = {W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      r = r | (d[i*W +: W] & {W{(IW'(i) == sel)}});
    end
    return r;
  endfunction

  // Round-robin scan starting just after ptr; wraps at N_REQ, not 2^IW.
  always_comb begin
    int            j;
    logic [IW-1:0] jj;
    j          = 0;
    jj         = {IW{1'b0}};
    pick_idx_s = ptr_r;
    pick_vld_s = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      j  = ((int'(ptr_r) + k) >= N_REQ) ? (int'(ptr_r) + k - N_REQ) : (int'(ptr_r) + k);
      jj = IW'(j);
      if (!pick_vld_s && in_valid[jj]) begin
        pick_vld_s = 1'b1;
        pick_idx_s = jj;
      end else begin
        pick_vld_s = pick_vld_s;
        pick_idx_s = pick_idx_s;
      end
    end
  end

  // Channel outputs: combinational mux path from the granted requester.
  always_comb begin
    out_valid_s = 1'b0;
    out_last_s  = 1'b0;
    out_data_s  = {W{1'b0}};
    in_ready_s  = {N_REQ{1'b0}};
    case (state_r)
      GRANT: begin
        out_valid_s = in_valid[grant_idx_r];
        out_last_s  = in_last[grant_idx_r];
        out_data_s  = mux_cell(in_data, grant_idx_r);
        in_ready_s  = grant_r & {N_REQ{out_ready}};
      end
      IDLE: begin
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        out_data_s  = {W{1'b0}};
        in_ready_s  = {N_REQ{1'b0}};
      end
      default: begin
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
        out_data_s  = {W{1'b0}};
        in_ready_s  = {N_REQ{1'b0}};
      end
    endcase
  end

  assign xfer_s = out_valid_s & out_ready;

`ifdef MUX_RR_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt_r;
  logic          forced_s;
  logic          burst_cut_r;

  // Forced release: this transfer is beat MAX_BURST of the grant and not last.
  assign forced_s  = xfer_s & ~out_last_s & (cnt_r == CW'(MAX_BURST - 1));
  assign release_s = xfer_s & (out_last_s | forced_s);

  // Beat counter for the current grant; cleared whenever the grant ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {CW{1'b0}};
      burst_cut_r <= 1'b0;
    end else begin
      burst_cut_r <= forced_s;
      if (state_r != GRANT) begin
        cnt_r <= {CW{1'b0}};
      end else if (xfer_s) begin
        cnt_r <= release_s ? {CW{1'b0}} : (cnt_r + CW'(1));
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign burst_cut = burst_cut_r;
`else
  assign release_s = xfer_s & out_last_s;
`endif

  // Next-state logic: grant on any request from IDLE, release on the packet end.
  always_comb begin
    state_nxt_s     = state_r;
    grant_nxt_s     = grant_r;
    grant_idx_nxt_s = grant_idx_r;
    ptr_nxt_s       = ptr_r;
    case (state_r)
      IDLE: begin
        if (pick_vld_s) begin
          state_nxt_s     = GRANT;
          grant_nxt_s     = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
          grant_idx_nxt_s = pick_idx_s;
        end else begin
          state_nxt_s     = IDLE;
          grant_nxt_s     = {N_REQ{1'b0}};
        end
      end
      GRANT: begin
        if (release_s) begin
          state_nxt_s = IDLE;
          grant_nxt_s = {N_REQ{1'b0}};
          ptr_nxt_s   = grant_idx_r;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = {N_REQ{1'b0}};
      end
    endcase
  end

  // State registers; ptr resets to N_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      grant_r     <= {N_REQ{1'b0}};
      grant_idx_r <= IW'(N_REQ - 1);
      ptr_r       <= IW'(N_REQ - 1);
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      grant_r     <= grant_nxt_s;
      grant_idx_r <= grant_idx_nxt_s;
      ptr_r       <= ptr_nxt_s;
      busy_r      <= (state_nxt_s == GRANT);
    end
  end

  assign grant     = grant_r;
  assign grant_idx = grant_idx_r;
  assign busy      = busy_r;
  assign out_valid = out_valid_s;
  assign out_last  = out_last_s;
  assign out_data  = out_data_s;
  assign in_ready  = in_ready_s;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: expected beats (requester, data, last,
// forced cut) are queued by the stimulus; a negedge monitor pops on every
// accepted beat and also checks grant/in_ready/idle-bubble behaviour.
module tb_mux_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;
`ifdef MUX_RR_ARB_BURST_LIMIT_EN
  localparam int MB = 2;
`else
  localparam int MB = 8;
`endif

  logic           clk, rst_n;
  logic [N-1:0]   in_valid, in_last, in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid, out_last, out_ready, busy;
  logic [W-1:0]   out_data;
  logic [N-1:0]   grant;
  logic [1:0]     grant_idx;
`ifdef MUX_RR_ARB_BURST_LIMIT_EN
  logic           burst_cut;
`endif

  mux_rr_arbiter #(.N_REQ(N), .W(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_last(out_last), .out_data(out_data), .out_ready(out_ready),
    .grant(grant), .grant_idx(grant_idx), .busy(busy)
`ifdef MUX_RR_ARB_BURST_LIMIT_EN
    , .burst_cut(burst_cut)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [1:0] idx; logic [7:0] data; logic last; logic cut;} exp_t;
  typedef struct packed {logic [7:0] data; logic last;} beat_t;

  exp_t   expq[$];
  beat_t  src[N][$];
  logic   rdy_q[$];
  logic [N-1:0] hold_off;
  int     checks, failures;
  exp_t   mon_e;
  logic   exp_idle_next, exp_cut_pend;
  logic [N-1:0] one_hot;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add_beat(int r, logic [7:0] d, logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    src[r].push_back(b);
  endtask

  task automatic expect_beat(logic [1:0] r, logic [7:0] d, logic l, logic c);
    exp_t e;
    e.idx = r; e.data = d; e.last = l; e.cut = c;
    expq.push_back(e);
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      in_valid[i]       = (src[i].size() > 0) && !hold_off[i];
      in_last[i]        = (src[i].size() > 0) ? src[i][0].last : 1'b0;
      in_data[i*W +: W] = (src[i].size() > 0) ? src[i][0].data : 8'h00;
    end
  endtask

  // One clock: sample acceptance mid-cycle, advance producers after the edge.
  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && src[i].size() > 0) void'(src[i].pop_front());
    out_ready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
    drive_srcs();
  endtask

  task automatic drain();
    int n;
    int pend;
    n = 0;
    pend = 1;
    while (pend != 0 && n < 300) begin
      step();
      n++;
      pend = expq.size();
      for (int i = 0; i < N; i++) pend += src[i].size();
    end
    if (pend != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d pending expected=0", pend);
    end
    step();
    step();
  endtask

  task automatic reset_dut();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  // Monitor: scoreboard pops on each accepted beat; per-cycle grant checks.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_idle_next = 1'b0;
      exp_cut_pend  = 1'b0;
    end else begin
      if (exp_idle_next) begin
        check("bubble_busy", busy, 0);
        check("bubble_valid", out_valid, 0);
        exp_idle_next = 1'b0;
      end
`ifdef MUX_RR_ARB_BURST_LIMIT_EN
      check("burst_cut", burst_cut, exp_cut_pend);
`endif
      exp_cut_pend = 1'b0;
      if (!busy) begin
        check("idle_grant", grant, 0);
        check("idle_in_ready", in_ready, 0);
        check("idle_out_data", out_data, 0);
        check("idle_out_valid", out_valid, 0);
      end else if (expq.size() > 0) begin
        one_hot = 4'b0001 << expq[0].idx;
        check("grant_onehot", grant, one_hot);
        check("grant_idx", grant_idx, expq[0].idx);
        check("in_ready_mirror", in_ready, out_ready ? one_hot : 4'b0000);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h expected=none", out_data);
        end else begin
          mon_e = expq.pop_front();
          check("beat_data", out_data, mon_e.data);
          check("beat_last", out_last, mon_e.last);
          exp_idle_next = mon_e.last | mon_e.cut;
          exp_cut_pend  = mon_e.cut;
        end
      end
    end
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0; out_ready = 1'b1;
    in_valid = '0; in_last = '0; in_data = '0; hold_off = '0;
    checks = 0; failures = 0; exp_idle_next = 1'b0; exp_cut_pend = 1'b0;

    // Reset values, then a single-beat packet right after release.
    add_beat(0, 8'hA5, 1'b1);
    drive_srcs();
    repeat (2) @(posedge clk);
    #2;
    check("rst_grant", grant, 0);
    check("rst_grant_idx", grant_idx, 3);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    expect_beat(2'd0, 8'hA5, 1'b1, 1'b0);
    @(posedge clk);
    #1 check("first_grant", grant, 4'b0001);
    drain();

    // ptr is now 0: requester 1 beats requester 0.
    add_beat(0, 8'h0A, 1'b1);
    add_beat(1, 8'h1B, 1'b1);
    drive_srcs();
    expect_beat(2'd1, 8'h1B, 1'b1, 1'b0);
    expect_beat(2'd0, 8'h0A, 1'b1, 1'b0);
    drain();

    // All four requesting single-beat packets from reset: 0,1,2,3,0.
    reset_dut();
    add_beat(0, 8'h10, 1'b1); add_beat(0, 8'h14, 1'b1);
    add_beat(1, 8'h11, 1'b1); add_beat(2, 8'h12, 1'b1); add_beat(3, 8'h13, 1'b1);
    drive_srcs();
    expect_beat(2'd0, 8'h10, 1'b1, 1'b0);
    expect_beat(2'd1, 8'h11, 1'b1, 1'b0);
    expect_beat(2'd2, 8'h12, 1'b1, 1'b0);
    expect_beat(2'd3, 8'h13, 1'b1, 1'b0);
    expect_beat(2'd0, 8'h14, 1'b1, 1'b0);
    drain();

`ifndef MUX_RR_ARB_BURST_LIMIT_EN
    // Requester 2, 3 beats, out_ready toggling 1,0,1,0,1.
    add_beat(2, 8'h21, 1'b0); add_beat(2, 8'h22, 1'b0); add_beat(2, 8'h23, 1'b1);
    drive_srcs();
    rdy_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    expect_beat(2'd2, 8'h21, 1'b0, 1'b0);
    expect_beat(2'd2, 8'h22, 1'b0, 1'b0);
    expect_beat(2'd2, 8'h23, 1'b1, 1'b0);
    drain();

    // Requester 1 stalls after beat 1 of 4 while requester 3 waits.
    add_beat(1, 8'h31, 1'b0); add_beat(1, 8'h32, 1'b0);
    add_beat(1, 8'h33, 1'b0); add_beat(1, 8'h34, 1'b1);
    drive_srcs();
    expect_beat(2'd1, 8'h31, 1'b0, 1'b0);
    expect_beat(2'd1, 8'h32, 1'b0, 1'b0);
    expect_beat(2'd1, 8'h33, 1'b0, 1'b0);
    expect_beat(2'd1, 8'h34, 1'b1, 1'b0);
    expect_beat(2'd3, 8'h3F, 1'b1, 1'b0);
    step();
    add_beat(3, 8'h3F, 1'b1);
    drive_srcs();
    step();
    hold_off[1] = 1'b1;
    drive_srcs();
    repeat (3) begin
      step();
      check("stall_valid", out_valid, 0);
      check("stall_grant", grant, 4'b0010);
    end
    hold_off = '0;
    drive_srcs();
    drain();
`endif

    // Asynchronous reset in mid-packet, then requester 0 beats 3.
    add_beat(0, 8'h41, 1'b0); add_beat(0, 8'h42, 1'b0); add_beat(0, 8'h43, 1'b1);
    drive_srcs();
    expect_beat(2'd0, 8'h41, 1'b0, 1'b0);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_grant", grant, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_grant_idx", grant_idx, 3);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) src[i].delete();
    add_beat(0, 8'h50, 1'b1);
    add_beat(3, 8'h53, 1'b1);
    drive_srcs();
    expect_beat(2'd0, 8'h50, 1'b1, 1'b0);
    expect_beat(2'd3, 8'h53, 1'b1, 1'b0);
    drain();

`ifdef MUX_RR_ARB_BURST_LIMIT_EN
    // MAX_BURST=2: requester 0 (5 beats) is cut every 2 beats; requester 1 slips in.
    reset_dut();
    add_beat(0, 8'h01, 1'b0); add_beat(0, 8'h02, 1'b0); add_beat(0, 8'h03, 1'b0);
    add_beat(0, 8'h04, 1'b0); add_beat(0, 8'h05, 1'b1);
    add_beat(1, 8'h11, 1'b1);
    drive_srcs();
    expect_beat(2'd0, 8'h01, 1'b0, 1'b0);
    expect_beat(2'd0, 8'h02, 1'b0, 1'b1);
    expect_beat(2'd1, 8'h11, 1'b1, 1'b0);
    expect_beat(2'd0, 8'h03, 1'b0, 1'b0);
    expect_beat(2'd0, 8'h04, 1'b0, 1'b1);
    expect_beat(2'd0, 8'h05, 1'b1, 1'b0);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
